immediate_unit: RTL and testbench

Parametrised, registered immediate generator for the application-specific processor's decode stage. It extracts and extends immediate fields from the instruction word and adds a prefix mechanism: one or more PFX instructions preload upper nibbles that the next immediate-using instruction concatenates with its own low nibble, giving immediates wider than the instruction encoding allows. Outputs are registered, one cycle after acceptance, with stall and flush control from the pipeline controller.

---
 rtl/immediate_unit.sv | 166 ++++++++++++++++
 tb/tb_immediate_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/immediate_unit.sv
// ----------------------------------------------------------------------------
// immediate_unit
// Registered immediate generator for the decode stage. Builds an immediate
// from the low five bits of the instruction word. PFX instructions preload
// upper nibbles that the next consuming instruction concatenates with its own
// low nibble. Outputs are registered, so each result appears one cycle after
// its input is accepted.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   in_valid       instruction/select valid this cycle
//   stall          hold every register and ignore the inputs
//   flush          drop the pending prefix and the current input (beats stall)
//   instruction    instruction word (fields come from bits [4:0])
//   select         extraction mode
//   immediate      registered immediate
//   out_valid      immediate belongs to the instruction accepted last cycle
//   prefix_pending prefix register holds unconsumed nibbles
//   ext_used       current immediate was built from a prefix
// ----------------------------------------------------------------------------
module immediate_unit #(
  parameter int DATA_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int PREFIX_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [2:0]         select,
  output logic [DATA_W-1:0]  immediate,
  output logic               out_valid,
  output logic               prefix_pending,
  output logic               ext_used
);

  localparam int EXT_W   = PREFIX_W + 4;
  localparam int NIB_MAX = PREFIX_W / 4;
  localparam int CNT_W   = $clog2(NIB_MAX + 1);

  localparam logic [2:0] SEL_ZX3 = 3'b000;
  localparam logic [2:0] SEL_ZX4 = 3'b001;
  localparam logic [2:0] SEL_SX5 = 3'b010;
  localparam logic [2:0] SEL_MOV = 3'b011;
  localparam logic [2:0] SEL_PFX = 3'b100;

  logic [DATA_W-1:0]   immediate_reg, immediate_next;
  logic                out_valid_reg, out_valid_next;
  logic                pending_reg, pending_next;
  logic                ext_used_reg, ext_used_next;
  logic [PREFIX_W-1:0] prefix_reg, prefix_next;
  logic [CNT_W-1:0]    count_reg, count_next;

  logic [PREFIX_W-1:0] prefix_shift;
  logic [EXT_W-1:0]    ext_field;
  logic [4:0]          field5;
  logic signed [DATA_W-1:0] sx_ext;
  logic signed [DATA_W-1:0] sx_field5;

  // Only instruction[4:0] carries immediate bits; the rest is opcode space.
  logic unused_instr;
  assign unused_instr = &{1'b0, instruction};

  // A chained PFX shifts the older nibbles up and drops the oldest one.
  // Bits not yet loaded stay zero because the register is cleared on every
  // consume, flush and reset.
  generate
    if (PREFIX_W == 4) begin : g_pfx_load
      assign prefix_shift = instruction[3:0];
    end else begin : g_pfx_shift
      assign prefix_shift = {prefix_reg[PREFIX_W-5:0], instruction[3:0]};
    end
  endgenerate

  assign ext_field = {prefix_reg, instruction[3:0]};
  assign field5    = instruction[4:0];
  // Assigning a signed narrower value to a signed wider one sign-extends.
  assign sx_ext    = $signed(ext_field);
  assign sx_field5 = $signed(field5);

  always_comb begin
    immediate_next = immediate_reg;
    out_valid_next = out_valid_reg;
    pending_next   = pending_reg;
    ext_used_next  = ext_used_reg;
    prefix_next    = prefix_reg;
    count_next     = count_reg;

    if (flush) begin
      out_valid_next = 1'b0;
      ext_used_next  = 1'b0;
      pending_next   = 1'b0;
      prefix_next    = '0;
      count_next     = '0;
    end else if (stall) begin
      // everything holds
    end else if (!in_valid) begin
      out_valid_next = 1'b0;
    end else begin
      unique case (select)
        SEL_PFX: begin
          prefix_next    = prefix_shift;
          count_next     = (count_reg == CNT_W'(NIB_MAX)) ? count_reg : count_reg + 1'b1;
          pending_next   = 1'b1;
          out_valid_next = 1'b0;
        end
        SEL_ZX3, SEL_ZX4, SEL_SX5: begin
          out_valid_next = 1'b1;
          if (pending_reg) begin
            immediate_next = (select == SEL_SX5) ? DATA_W'(sx_ext) : DATA_W'(ext_field);
            ext_used_next  = 1'b1;
            pending_next   = 1'b0;
            prefix_next    = '0;
            count_next     = '0;
          end else begin
            ext_used_next = 1'b0;
            if (select == SEL_ZX3)
              immediate_next = DATA_W'(instruction[4:2]);
            else if (select == SEL_ZX4)
              immediate_next = DATA_W'(instruction[3:0]);
            else
              immediate_next = DATA_W'(sx_field5);
          end
        end
        SEL_MOV: begin
          // MOV carries no immediate and leaves any prefix for a later consumer.
          immediate_next = '0;
          out_valid_next = 1'b1;
          ext_used_next  = 1'b0;
        end
        default: begin
          immediate_next = '0;
          out_valid_next = 1'b1;
          ext_used_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      immediate_reg <= '0;
      out_valid_reg <= 1'b0;
      pending_reg   <= 1'b0;
      ext_used_reg  <= 1'b0;
      prefix_reg    <= '0;
      count_reg     <= '0;
    end else begin
      immediate_reg <= immediate_next;
      out_valid_reg <= out_valid_next;
      pending_reg   <= pending_next;
      ext_used_reg  <= ext_used_next;
      prefix_reg    <= prefix_next;
      count_reg     <= count_next;
    end
  end

  assign immediate      = immediate_reg;
  assign out_valid      = out_valid_reg;
  assign prefix_pending = pending_reg;
  assign ext_used       = ext_used_reg;

endmodule

// File: tb/tb_immediate_unit.sv
// ----------------------------------------------------------------------------
// tb_immediate_unit
// Directed bench for immediate_unit. Two instances share one stimulus stream:
// an 8-bit build (PREFIX_W=4) and a 16-bit build (PREFIX_W=8). Inputs change
// 1 ns after a rising edge and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_immediate_unit;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       stall;
  logic       flush;
  logic [7:0] instruction;
  logic [2:0] select;

  logic [7:0]  imm8;
  logic        ov8, pend8, ext8;
  logic [15:0] imm16;
  logic        ov16, pend16, ext16;

  int checks   = 0;
  int failures = 0;

  immediate_unit #(.DATA_W(8), .INSTR_W(8), .PREFIX_W(4)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
    .flush(flush), .instruction(instruction), .select(select),
    .immediate(imm8), .out_valid(ov8), .prefix_pending(pend8), .ext_used(ext8)
  );

  immediate_unit #(.DATA_W(16), .INSTR_W(8), .PREFIX_W(8)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
    .flush(flush), .instruction(instruction), .select(select),
    .immediate(imm16), .out_valid(ov16), .prefix_pending(pend16), .ext_used(ext16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic cyc(input logic v, input logic s, input logic f,
                     input logic [2:0] sel, input logic [7:0] ins);
    in_valid    = v;
    stall       = s;
    flush       = f;
    select      = sel;
    instruction = ins;
    @(posedge clk);
    #1;
    $display("step v=%b stall=%b flush=%b sel=%b ins=%h -> imm8=%h ov8=%b pend8=%b ext8=%b imm16=%h ov16=%b pend16=%b ext16=%b",
             v, s, f, sel, ins, imm8, ov8, pend8, ext8, imm16, ov16, pend16, ext16);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    select = 3'b000; instruction = 8'h00;

    // reset state, before any clock edge
    #3;
    chk("rst_imm8", {8'h00, imm8}, 16'h0000);
    chk("rst_ov8", {15'd0, ov8}, 16'd0);
    chk("rst_pend8", {15'd0, pend8}, 16'd0);
    chk("rst_ext8", {15'd0, ext8}, 16'd0);
    chk("rst_imm16", imm16, 16'h0000);
    @(posedge clk); #3;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 3'b000, 8'h00);
    chk("idle_ov8", {15'd0, ov8}, 16'd0);

    // basic modes
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 8'h1C);
    chk("m000_imm8", {8'h00, imm8}, 16'h0007);
    chk("m000_ov8", {15'd0, ov8}, 16'd1);
    chk("m000_ext8", {15'd0, ext8}, 16'd0);
    chk("m000_imm16", imm16, 16'h0007);
    cyc(1'b1, 1'b0, 1'b0, 3'b010, 8'h13);
    chk("m010_imm8", {8'h00, imm8}, 16'h00F3);
    chk("m010_imm16", imm16, 16'hFFF3);
    // a stalled input must not disturb the held result
    cyc(1'b1, 1'b1, 1'b0, 3'b000, 8'h1C);
    chk("stall_imm8", {8'h00, imm8}, 16'h00F3);
    chk("stall_ov8", {15'd0, ov8}, 16'd1);
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'hAF);
    chk("m001_imm8", {8'h00, imm8}, 16'h000F);
    chk("m001_imm16", imm16, 16'h000F);
    cyc(1'b1, 1'b0, 1'b0, 3'b011, 8'h1F);
    chk("m011_imm8", {8'h00, imm8}, 16'h0000);
    chk("m011_ov8", {15'd0, ov8}, 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 3'b011, 8'h00);
    chk("bubble_ov8", {15'd0, ov8}, 16'd0);

    // prefix, back to back
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h0A);
    chk("pfxA_pend8", {15'd0, pend8}, 16'd1);
    chk("pfxA_ov8", {15'd0, ov8}, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'h05);
    chk("pfxA_imm8", {8'h00, imm8}, 16'h00A5);
    chk("pfxA_ext8", {15'd0, ext8}, 16'd1);
    chk("pfxA_pend8_clr", {15'd0, pend8}, 16'd0);
    chk("pfxA_ov8_set", {15'd0, ov8}, 16'd1);
    chk("pfxA_imm16", imm16, 16'h00A5);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h08);
    cyc(1'b1, 1'b0, 1'b0, 3'b010, 8'h03);
    chk("pfx8_imm8", {8'h00, imm8}, 16'h0083);
    chk("pfx8_imm16", imm16, 16'h0083);

    // MOV keeps the prefix
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h0A);
    chk("pfx_hold_imm8", {8'h00, imm8}, 16'h0083);
    cyc(1'b1, 1'b0, 1'b0, 3'b011, 8'h00);
    chk("mov_imm8", {8'h00, imm8}, 16'h0000);
    chk("mov_pend8", {15'd0, pend8}, 16'd1);
    chk("mov_ext8", {15'd0, ext8}, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'h05);
    chk("mov_then_imm8", {8'h00, imm8}, 16'h00A5);
    chk("mov_then_ext8", {15'd0, ext8}, 16'd1);

    // stall then flush
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h0C);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 3'b001, 8'h05);
      chk("stall_pfx_ov8", {15'd0, ov8}, 16'd0);
      chk("stall_pfx_pend8", {15'd0, pend8}, 16'd1);
    end
    cyc(1'b1, 1'b1, 1'b1, 3'b100, 8'h0B);
    chk("flush_pend8", {15'd0, pend8}, 16'd0);
    chk("flush_ov8", {15'd0, ov8}, 16'd0);
    chk("flush_ext8", {15'd0, ext8}, 16'd0);
    chk("flush_imm8", {8'h00, imm8}, 16'h00A5);
    chk("flush_pend16", {15'd0, pend16}, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'h05);
    chk("post_flush_imm8", {8'h00, imm8}, 16'h0005);
    chk("post_flush_ext8", {15'd0, ext8}, 16'd0);

    // reserved mode
    cyc(1'b1, 1'b0, 1'b0, 3'b110, 8'h1F);
    chk("rsv_imm8", {8'h00, imm8}, 16'h0000);
    chk("rsv_ov8", {15'd0, ov8}, 16'd1);

    // asynchronous reset mid-chain
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'hAF);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h0A);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_imm8", {8'h00, imm8}, 16'h0000);
    chk("arst_pend8", {15'd0, pend8}, 16'd0);
    chk("arst_ov8", {15'd0, ov8}, 16'd0);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 3'b000, 8'h00);
    chk("arst_idle_ov8", {15'd0, ov8}, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'h05);
    chk("arst_next_imm8", {8'h00, imm8}, 16'h0005);
    chk("arst_next_ext8", {15'd0, ext8}, 16'd0);

    // chained prefixes on the 16-bit build
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h01);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h02);
    chk("chain2_pend16", {15'd0, pend16}, 16'd1);
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'h03);
    chk("chain2_imm16", imm16, 16'h0123);
    chk("chain2_ext16", {15'd0, ext16}, 16'd1);
    chk("chain2_pend16_clr", {15'd0, pend16}, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h0F);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h0F);
    cyc(1'b1, 1'b0, 1'b0, 3'b010, 8'h0E);
    chk("chainF_imm16", imm16, 16'hFFFE);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h01);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h02);
    cyc(1'b1, 1'b0, 1'b0, 3'b100, 8'h03);
    cyc(1'b1, 1'b0, 1'b0, 3'b001, 8'h04);
    chk("chain3_imm16", imm16, 16'h0234);
    chk("chain3_ov16", {15'd0, ov16}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
